mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter sharing one external signed 32x32
//               multiplier between two requesters. The winning operands are
//               registered onto mul_a/mul_b, the product is captured after
//               LATENCY cycles and returned with a one-cycle strobe and an
//               owner tag.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int LATENCY = 2   // cycles given to the external multiplier (1..15)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    output logic [63:0] res,
    output logic        res_valid,
    output logic        res_id,
    output logic        busy
);

    // Counter load value; LATENCY is bounded to 1..15 so it fits in 4 bits.
    localparam logic [3:0] c_LAT_LOAD = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;        // cycles left before the product is captured
    logic        owner_q;      // requester that owns the operation in flight
    logic        last_q;       // requester granted most recently
    logic        gnt0_q;
    logic        gnt1_q;
    logic        res_valid_q;
    logic        res_id_q;
    logic [31:0] mul_a_q;
    logic [31:0] mul_b_q;
    logic [63:0] res_q;

    logic        w_any_req;
    logic        w_win;        // 0: requester 0 wins, 1: requester 1 wins

    // Round-robin pick: a lone requester wins; on contention the one not
    // granted last time wins.
    always_comb begin
        w_any_req = req0 | req1;
        w_win     = req1 & (~req0 | ~last_q);
    end

    // Operation FSM with all outputs registered; grant and result strobes
    // default low so they only ever last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;   // requester 0 wins the first contention
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            mul_a_q     <= 32'd0;
            mul_b_q     <= 32'd0;
            res_q       <= 64'd0;
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_any_req) begin
                        mul_a_q <= w_win ? a1 : a0;
                        mul_b_q <= w_win ? b1 : b0;
                        gnt0_q  <= ~w_win;
                        gnt1_q  <= w_win;
                        cnt_q   <= c_LAT_LOAD;
                        owner_q <= w_win;
                        last_q  <= w_win;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Operands stay frozen; the product is taken on the last
                    // counted edge.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        res_q       <= mul_p;
                        res_id_q    <= owner_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
